// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon byte-serial input stage.
package simon_pkg;

    typedef enum logic [2:0] {
        S_CMD,
        S_KEY,
        S_PT,
        S_OUT,
        S_DROP
    } state_e;

    localparam int CMD_MODE_BIT = 0;
    localparam int CMD_KEEP_BIT = 1;

    function automatic int key_bytes(int ww, int nkw);
        return ww * nkw / 8;
    endfunction

    function automatic int pt_bytes(int ww);
        return 2 * ww / 8;
    endfunction

endpackage

// File: rtl/simon_byte_ctr.sv
// Frame byte counter with clear/enable and terminal-count flags
// for the last key byte and the last plaintext byte.
module simon_byte_ctr #(
    parameter int KB = 8,
    parameter int PB = 4,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt_o,
    output logic          tc_key_o,
    output logic          tc_pt_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign tc_key_o = (cnt_q == CW'(KB - 1));
    assign tc_pt_o  = (cnt_q == CW'(PB - 1));

endmodule

// File: rtl/simon_byte_loader.sv
// Byte-serial CMD/key/plaintext frame assembler feeding the Simon
// cipher top, with stored-key reuse and framing-error detection.
module simon_byte_loader
    import simon_pkg::*;
#(
    parameter int WW  = 16,
    parameter int NKW = 4
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [7:0]        in_data_i,
    input  logic              in_last_i,
    output logic              err_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              mode_o,
    output logic [2*WW-1:0]   pt_o,
    output logic [NKW*WW-1:0] key_o,
    output logic              key_valid_o
);

    localparam int KB = key_bytes(WW, NKW);
    localparam int PB = pt_bytes(WW);
    localparam int CW = $clog2((KB > PB) ? KB : PB);

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic              kv_q, kv_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    logic [2*WW-1:0]   pt_q, pt_d;
    logic [NKW*WW-1:0] key_q, key_d;

    logic          acc;
    logic          keep;
    logic          ctr_clr;
    logic          ctr_en;
    logic [CW-1:0] cnt;
    logic          tc_key;
    logic          tc_pt;

    assign in_ready_o = (state_q != S_OUT);
    assign acc        = in_valid_i & in_ready_o;
    assign keep       = in_data_i[CMD_KEEP_BIT];

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        kv_d    = kv_q;
        err_d   = 1'b0;
        pt_d    = pt_q;
        key_d   = key_q;
        case (state_q)
            S_CMD: if (acc) begin
                mode_d = in_data_i[CMD_MODE_BIT];
                if (in_data_i[7:2] != '0 || (keep && !kv_q)
                    || in_last_i) begin
                    err_d   = 1'b1;
                    state_d = in_last_i ? S_CMD : S_DROP;
                end else begin
                    state_d = keep ? S_PT : S_KEY;
                end
            end
            S_KEY: if (acc) begin
                key_d[8*int'(cnt) +: 8] = in_data_i;
                if (cnt == '0) begin
                    kv_d = 1'b0;
                end
                // a key byte can never end a frame
                if (in_last_i) begin
                    err_d   = 1'b1;
                    state_d = S_CMD;
                end else if (tc_key) begin
                    kv_d    = 1'b1;
                    state_d = S_PT;
                end
            end
            S_PT: if (acc) begin
                pt_d[8*int'(cnt) +: 8] = in_data_i;
                if (tc_pt) begin
                    err_d   = !in_last_i;
                    state_d = in_last_i ? S_OUT : S_DROP;
                end else if (in_last_i) begin
                    err_d   = 1'b1;
                    state_d = S_CMD;
                end
            end
            S_OUT: if (ready_i) begin
                state_d = S_CMD;
            end
            S_DROP: if (acc && in_last_i) begin
                state_d = S_CMD;
            end
            default: state_d = S_CMD;
        endcase
    end

    assign valid_d = (state_d == S_OUT);
    assign ctr_clr = (state_d != state_q);
    assign ctr_en  = acc && (state_q == S_KEY || state_q == S_PT);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= S_CMD;
            mode_q  <= 1'b0;
            kv_q    <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            pt_q    <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            kv_q    <= kv_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            pt_q    <= pt_d;
            key_q   <= key_d;
        end
    end

    simon_byte_ctr #(
        .KB(KB),
        .PB(PB),
        .CW(CW)
    ) u_ctr (
        .clk     (clk),
        .arst    (arst),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .cnt_o   (cnt),
        .tc_key_o(tc_key),
        .tc_pt_o (tc_pt)
    );

    assign err_o       = err_q;
    assign valid_o     = valid_q;
    assign mode_o      = mode_q;
    assign pt_o        = pt_q;
    assign key_o       = key_q;
    assign key_valid_o = kv_q;

endmodule

// File: tb/tb_simon_byte_loader.sv
// Bench for simon_byte_loader (Simon 32/64): directed table, corner
// sequences and random frames against a frame-level reference model.
module tb_simon_byte_loader;

    localparam int WW  = 16;
    localparam int NKW = 4;
    localparam int KB  = 8;
    localparam int PB  = 4;

    logic          clk = 1'b0;
    logic          arst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready_o;
    logic [7:0]    in_data = 8'h00;
    logic          in_last = 1'b0;
    logic          err_o;
    logic          valid_o;
    logic          ready = 1'b0;
    logic          mode_o;
    logic [31:0]   pt_o;
    logic [63:0]   key_o;
    logic          key_valid_o;

    simon_byte_loader #(.WW(WW), .NKW(NKW)) dut (
        .clk        (clk),
        .arst       (arst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready_o),
        .in_data_i  (in_data),
        .in_last_i  (in_last),
        .err_o      (err_o),
        .valid_o    (valid_o),
        .ready_i    (ready),
        .mode_o     (mode_o),
        .pt_o       (pt_o),
        .key_o      (key_o),
        .key_valid_o(key_valid_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: position within the frame decides the byte role.
    bit          m_kv, m_mode, m_keep, m_drop, m_err, m_emit;
    logic [63:0] m_key;
    logic [31:0] m_pt;
    int          m_pos, m_len;

    task automatic m_reset();
        m_kv = 0; m_mode = 0; m_keep = 0; m_drop = 0;
        m_key = '0; m_pt = '0; m_pos = 0; m_len = 1;
    endtask

    task automatic m_step(input logic [7:0] b, input logic last);
        bit bad;
        m_err = 0;
        m_emit = 0;
        bad = 0;
        if (m_drop) begin
            if (last) begin
                m_drop = 0;
                m_pos = 0;
            end
            return;
        end
        if (m_pos == 0) begin
            m_mode = b[0];
            m_keep = b[1];
            m_len = m_keep ? 1 + PB : 1 + KB + PB;
            bad = (b[7:2] != 0) || (m_keep && !m_kv);
        end else if (!m_keep && m_pos <= KB) begin
            if (m_pos == 1) m_kv = 0;
            m_key[8*(m_pos-1) +: 8] = b;
        end else begin
            m_pt[8*(m_pos - (m_keep ? 1 : 1 + KB)) +: 8] = b;
        end
        if (last != (m_pos == m_len - 1)) bad = 1;
        if (!m_keep && m_pos == KB && !bad) m_kv = 1;
        if (bad) begin
            m_err = 1;
            if (last) m_pos = 0;
            else m_drop = 1;
        end else if (m_pos == m_len - 1) begin
            m_emit = 1;
            m_pos = 0;
        end else begin
            m_pos++;
        end
    endtask

    int hold_next = 0;
    bit skip_drain = 0;

    task automatic drain(input int hold);
        chk("busy_in_ready", in_ready_o, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", valid_o, 1);
            chk("hold_in_ready", in_ready_o, 0);
            chk("hold_mode", mode_o, m_mode);
            chk("hold_pt", pt_o, m_pt);
            chk("hold_key", key_o, m_key);
        end
        ready = 1;
        @(posedge clk); #1;
        ready = 0;
        chk("post_hs_valid", valid_o, 0);
        chk("post_hs_in_ready", in_ready_o, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last,
                             output logic ge, output logic gv,
                             output logic gm, output logic [31:0] gp,
                             output logic [63:0] gk);
        int n = 0;
        in_valid = 1; in_data = b; in_last = last;
        while (!in_ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", in_ready_o, 1);
        @(posedge clk); #1;
        in_valid = 0;
        in_data = 8'($urandom);
        in_last = 1'($urandom);
        ge = err_o; gv = valid_o; gm = mode_o; gp = pt_o; gk = key_o;
        m_step(b, last);
        chk("err_o", err_o, m_err);
        chk("valid_o", valid_o, m_emit);
        chk("key_valid_o", key_valid_o, m_kv);
        if (m_emit) begin
            chk("mode_o", mode_o, m_mode);
            chk("pt_o", pt_o, m_pt);
            chk("key_o", key_o, m_key);
            if (!skip_drain) drain(hold_next);
        end
    endtask

    task automatic do_reset();
        in_valid = 0;
        ready = 0;
        arst = 1;
        #3;
        chk("rst_valid", valid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_kv", key_valid_o, 0);
        chk("rst_mode", mode_o, 0);
        chk("rst_pt", pt_o, 0);
        chk("rst_key", key_o, 0);
        chk("rst_in_ready", in_ready_o, 1);
        @(posedge clk); #1;
        arst = 0;
        @(posedge clk); #1;
        chk("rel_in_ready", in_ready_o, 1);
        m_reset();
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        last;
        int          hold;
        logic        exp_err;
        logic        exp_valid;
        logic        exp_mode;
        logic [31:0] exp_pt;
        logic [63:0] exp_key;
    } vec_t;

    vec_t tbl[$];
    logic [7:0] f1[13] = '{8'h00, 8'h00, 8'h01, 8'h08, 8'h09, 8'h10,
                           8'h11, 8'h18, 8'h19, 8'h77, 8'h68, 8'h65,
                           8'h65};
    logic [7:0] f3[5]  = '{8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    localparam logic [63:0] K1 = 64'h1918111009080100;

    task automatic send_f1(input int hold);
        logic ge, gv, gm;
        logic [31:0] gp;
        logic [63:0] gk;
        hold_next = hold;
        for (int i = 0; i < 13; i++) begin
            send_byte(f1[i], i == 12, ge, gv, gm, gp, gk);
        end
        chk("f1_valid", gv, 1);
        chk("f1_pt", gp, 32'h65656877);
        chk("f1_key", gk, K1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic ge, gv, gm;
        logic [31:0] gp;
        logic [63:0] gk;
        logic [7:0] qb[$];
        logic       ql[$];

        m_reset();
        #1;
        do_reset();

        for (int i = 0; i < 13; i++)
            tbl.push_back('{f1[i], i == 12, 10, 0, i == 12, 0,
                            32'h65656877, K1});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{f3[i], i == 4, 0, 0, i == 4, 1,
                            32'hDDCCBBAA, K1});
        foreach (tbl[i]) begin
            hold_next = tbl[i].hold;
            send_byte(tbl[i].data, tbl[i].last, ge, gv, gm, gp, gk);
            chk("tbl_err", ge, tbl[i].exp_err);
            chk("tbl_valid", gv, tbl[i].exp_valid);
            if (tbl[i].exp_valid) begin
                chk("tbl_mode", gm, tbl[i].exp_mode);
                chk("tbl_pt", gp, tbl[i].exp_pt);
                chk("tbl_key", gk, tbl[i].exp_key);
            end
        end
        chk("tbl_kv", key_valid_o, 1);

        // keep requested with no stored key
        do_reset();
        send_byte(8'h02, 0, ge, gv, gm, gp, gk);
        chk("nokey_err", ge, 1);
        send_byte(8'h11, 0, ge, gv, gm, gp, gk);
        chk("drop_err", ge, 0);
        send_byte(8'h22, 0, ge, gv, gm, gp, gk);
        send_byte(8'h44, 1, ge, gv, gm, gp, gk);
        chk("drop_valid", gv, 0);

        // early last inside the key field
        for (int i = 0; i < 5; i++) begin
            send_byte(f1[i], i == 4, ge, gv, gm, gp, gk);
            chk("early_err", ge, i == 4);
        end
        chk("early_kv", key_valid_o, 0);
        chk("early_in_ready", in_ready_o, 1);
        send_f1(1);

        // reset mid key, then mid output hold
        send_byte(8'h00, 0, ge, gv, gm, gp, gk);
        send_byte(8'h00, 0, ge, gv, gm, gp, gk);
        send_byte(8'h01, 0, ge, gv, gm, gp, gk);
        do_reset();
        send_f1(0);
        skip_drain = 1;
        send_f1(0);
        skip_drain = 0;
        do_reset();
        send_f1(2);

        for (int f = 0; f < 300; f++) begin
            bit keep, mode;
            int kind, len, cut;
            logic [7:0] cmd;
            hold_next = $urandom_range(0, 3);
            keep = 1'($urandom_range(0, 1));
            mode = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 7);
            cmd = {6'b0, keep, mode};
            if (kind == 0) cmd[7:2] = 6'($urandom_range(1, 63));
            len = keep ? 1 + PB : 1 + KB + PB;
            qb.delete();
            ql.delete();
            for (int i = 0; i < len; i++) begin
                qb.push_back(i == 0 ? cmd : 8'($urandom));
                ql.push_back(i == len - 1);
            end
            if (kind == 1) begin
                cut = $urandom_range(0, len - 2);
                while (qb.size() > cut + 1) begin
                    void'(qb.pop_back());
                    void'(ql.pop_back());
                end
                ql[cut] = 1;
            end else if (kind == 2) begin
                ql[len-1] = 0;
                qb.push_back(8'($urandom));
                ql.push_back(1);
            end
            foreach (qb[i]) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 2)) @(posedge clk);
                    #1;
                end
                send_byte(qb[i], ql[i], ge, gv, gm, gp, gk);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
